branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Parametrised successor to the combinational B-type compare unit. Resolves conditional branches in a registered EX stage and computes the redirect PC and mispredict flag.
- Owns a PC-indexed table of 2-bit saturating counters (BHT). IF reads it combinationally for the taken prediction.
- Sits between ID/EX and EX/MEM with a valid/ready handshake on both sides.

Parameters:
- XLEN, 32, operand and PC width (>=8).
- BHT_DEPTH, 64, BHT entries; power of two, >=2.
- BHT_INIT, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- lookup_pc_i  in  XLEN  IF-stage PC for prediction.
- pred_taken_o  out  1  combinational prediction for lookup_pc_i.
- valid_i  in  1  branch op offered.
- ready_o  out  1  unit can accept an op.
- pc_i  in  XLEN  PC of the branch.
- op_a_i  in  XLEN  rs1 value.
- op_b_i  in  XLEN  rs2 value.
- imm_i  in  XLEN  sign-extended branch offset.
- opcode_i  in  4  0 EQ, 1 NEQ, 2 ULT, 3 SLT, 4 UGE, 5 SGE; others illegal.
- pred_taken_i  in  1  prediction made in IF for this branch.
- flush_i  in  1  kill the accepted op and any held result.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- taken_o  out  1  resolved direction.
- mispredict_o  out  1  taken_o != registered pred_taken_i.
- redirect_pc_o  out  XLEN  correct next PC.
- illegal_o  out  1  opcode was not 0..5.

Behaviour:
- Index width IW = log2(BHT_DEPTH). Index = pc[IW+1:2] for both lookup and update.
- pred_taken_o = bht[index(lookup_pc_i)][1]. Purely combinational.
- Accept: a capture occurs when valid_i && ready_o && !flush_i. ready_o = !valid_o || ready_i.
- Latency: result registered, visible one cycle after the capture.
- Stall: when valid_o && !ready_i, all outputs hold stable.
- Compare rules, all XLEN-wide:
  - EQ/NEQ: a==b / a!=b.
  - ULT/UGE: unsigned a<b / a>=b.
  - SLT/SGE: signed comparison. If the sign bits differ, the result comes from the sign bits alone, so it never overflows.
- Illegal opcode: taken_o=0, illegal_o=1, mispredict_o = pred_taken_i. No BHT update.
- redirect_pc_o = taken ? pc+imm : pc+4, modulo 2^XLEN; wrap-around is allowed.
- BHT update fires once per branch, on output handshake (valid_o && ready_i && !flush_i && !illegal_o):
  - taken: counter += 1, saturating at 3.
  - not taken: counter -= 1, saturating at 0.
- Same-index lookup in the update cycle returns the pre-update value; there is no bypass.
- flush_i:
  - Next cycle valid_o=0.
  - A same-cycle capture is dropped.
  - A held result is discarded without a BHT update.
  - flush_i has priority over capture and handshake.
- Back-to-back ops: with ready_i=1, one op per cycle, sustained.
- Reset (asynchronous, any time including mid-operation):
  - valid_o=0, taken_o=0, mispredict_o=0, illegal_o=0, redirect_pc_o=0.
  - All counters = BHT_INIT, so pred_taken_o=BHT_INIT[1].
  - ready_o=1 immediately after reset.

Test Plan:
- Signed edge: SLT a=0x80000000, b=0x00000001, pc=0x100, imm=0x20, pred=0 -> next cycle valid_o=1, taken_o=1, mispredict_o=1, redirect_pc_o=0x120.
- Unsigned and wrap: UGE a=0xFFFFFFFF, b=0, pc=0xFFFFFFF0, imm=0x20 -> taken_o=1, redirect_pc_o=0x00000010. BNE a=b=5 at pc=0x40 -> taken_o=0, redirect_pc_o=0x44.
- Saturation: four taken BEQ at pc=0x200 (BHT_DEPTH=64) -> lookup 0x200 gives pred_taken_o: 0 after reset, 1 after the 1st update, still 1 after the 4th (counter=3). Three not-taken then give pred 1,0,0.
- Backpressure: ready_i=0 for 3 cycles while valid_o=1 -> ready_o=0, outputs constant, single BHT update on the eventual handshake. A second op offered meanwhile is accepted the cycle ready_i rises.
- Flush: flush_i with a held result plus a new valid_i -> valid_o=0 next cycle, BHT entries unchanged. Opcode 4'hA -> illegal_o=1, taken_o=0, no BHT change.
- Reset mid-stall: assert rst_n_i=0 asynchronously while valid_o=1 and counters trained -> valid_o=0 without a clock edge. All lookups return BHT_INIT[1] after release.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Registered EX-stage branch resolver: compares operands, computes the redirect PC and
// mispredict flag, and trains a PC-indexed table of 2-bit saturating counters.
module branch_resolve_unit #(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] BHT_INIT  = 2'b01
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  // IF-stage prediction port
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            pred_taken_o,
  // ID/EX side
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [3:0]      opcode_i,
  input  logic            pred_taken_i,
  input  logic            flush_i,
  // EX/MEM side
  output logic            valid_o,
  input  logic            ready_i,
  output logic            taken_o,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            illegal_o
);

  localparam int IW = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  typedef enum logic [3:0] {
    OP_EQ  = 4'd0,
    OP_NEQ = 4'd1,
    OP_ULT = 4'd2,
    OP_SLT = 4'd3,
    OP_UGE = 4'd4,
    OP_SGE = 4'd5
  } br_op_e;

  logic [1:0]      bht [BHT_DEPTH];

  logic [IW-1:0]   lookup_idx;
  logic [IW-1:0]   cap_idx;

  logic            valid_q;
  logic            taken_q;
  logic            mispredict_q;
  logic            illegal_q;
  logic [XLEN-1:0] redirect_q;
  logic [IW-1:0]   idx_q;

  logic            capture;
  logic            out_fire;
  logic            bht_update;

  logic            a_eq_b;
  logic            a_ult_b;
  logic            a_slt_b;
  logic            taken_d;
  logic            illegal_d;
  logic            mispredict_d;
  logic [XLEN-1:0] redirect_d;

  // Only the word-aligned index bits of either PC select a counter.
  logic            unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i, pc_i};

  assign lookup_idx   = lookup_pc_i[IW+1:2];
  assign cap_idx      = pc_i[IW+1:2];

  // No bypass: a lookup in the update cycle sees the pre-update counter.
  assign pred_taken_o = bht[lookup_idx][1];

  assign ready_o    = !valid_q || ready_i;
  assign capture    = valid_i && ready_o && !flush_i;
  assign out_fire   = valid_q && ready_i && !flush_i;
  assign bht_update = out_fire && !illegal_q;

  assign valid_o       = valid_q;
  assign taken_o       = taken_q;
  assign mispredict_o  = mispredict_q;
  assign illegal_o     = illegal_q;
  assign redirect_pc_o = redirect_q;

  // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    taken_d   = 1'b0;
    illegal_d = 1'b0;

    a_eq_b  = (op_a_i == op_b_i);
    a_ult_b = (op_a_i <  op_b_i);
    // Differing signs decide on their own; equal signs reduce to the unsigned compare.
    a_slt_b = (op_a_i[XLEN-1] != op_b_i[XLEN-1]) ? op_a_i[XLEN-1] : a_ult_b;

    case (opcode_i)
      OP_EQ:   taken_d = a_eq_b;
      OP_NEQ:  taken_d = !a_eq_b;
      OP_ULT:  taken_d = a_ult_b;
      OP_SLT:  taken_d = a_slt_b;
      OP_UGE:  taken_d = !a_ult_b;
      OP_SGE:  taken_d = !a_slt_b;
      default: illegal_d = 1'b1;
    endcase

    // Illegal ops resolve not-taken, so this also yields mispredict = pred_taken_i.
    mispredict_d = taken_d ^ pred_taken_i;
    redirect_d   = taken_d ? (pc_i + imm_i) : (pc_i + XLEN'(4));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      redirect_q   <= '0;
      idx_q        <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q      <= 1'b1;
      taken_q      <= taken_d;
      mispredict_q <= mispredict_d;
      illegal_q    <= illegal_d;
      redirect_q   <= redirect_d;
      idx_q        <= cap_idx;
    end else if (out_fire) begin
      valid_q <= 1'b0;
    end
  end

  // NOTE: the table is reset entry by entry because the prediction must read BHT_INIT right after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= BHT_INIT;
      end
    end else if (bht_update) begin
      if (taken_q) begin
        if (bht[idx_q] != 2'b11) bht[idx_q] <= bht[idx_q] + 2'b01;
      end else begin
        if (bht[idx_q] != 2'b00) bht[idx_q] <= bht[idx_q] - 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: table of compare vectors streamed back-to-back,
// then hand-written sequences for counter saturation, backpressure, flush and async reset.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] lookup_pc;
  logic        pred_taken_out;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] pc;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] imm;
  logic [3:0]  opcode;
  logic        pred_taken_in;
  logic        flush;
  logic        valid_out;
  logic        ready_in;
  logic        taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        illegal;

  int n_chk = 0;
  int n_err = 0;

  branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(64), .BHT_INIT(2'b01)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .lookup_pc_i   (lookup_pc),
    .pred_taken_o  (pred_taken_out),
    .valid_i       (valid_in),
    .ready_o       (ready_out),
    .pc_i          (pc),
    .op_a_i        (op_a),
    .op_b_i        (op_b),
    .imm_i         (imm),
    .opcode_i      (opcode),
    .pred_taken_i  (pred_taken_in),
    .flush_i       (flush),
    .valid_o       (valid_out),
    .ready_i       (ready_in),
    .taken_o       (taken),
    .mispredict_o  (mispredict),
    .redirect_pc_o (redirect_pc),
    .illegal_o     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
    logic        exp_taken;
    logic        exp_mis;
    logic        exp_ill;
    logic [31:0] exp_rpc;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, input logic [31:0] i, input logic pr);
    valid_in      = 1'b1;
    opcode        = o;
    op_a          = a;
    op_b          = b;
    pc            = p;
    imm           = i;
    pred_taken_in = pr;
  endtask

  // Returns on a falling edge with reset released and inputs idle.
  task automatic do_reset();
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    flush     = 1'b0;
    ready_in  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One taken BEQ through the unit with ready_i high; starts and ends on a falling edge.
  task automatic taken_op(input logic [31:0] p);
    drive_op(4'd0, 32'd7, 32'd7, p, 32'h10, 1'b0);
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] held_rpc;
  logic        prev_pred;
  logic        sat_exp[7];

  initial begin
    vecs[0]  = '{4'd0,  32'd5,        32'd5,        32'h0000_1000, 32'h10,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1010};
    vecs[1]  = '{4'd1,  32'd5,        32'd5,        32'h0000_0040, 32'h8,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0044};
    vecs[2]  = '{4'd2,  32'd1,        32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0070};
    vecs[3]  = '{4'd3,  32'h8000_0000, 32'd1,       32'h0000_0100, 32'h20,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0120};
    vecs[4]  = '{4'd3,  32'd1,        32'h8000_0000, 32'h0000_0104, 32'h20,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0108};
    vecs[5]  = '{4'd4,  32'hFFFF_FFFF, 32'd0,       32'hFFFF_FFF0, 32'h20,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010};
    vecs[6]  = '{4'd5,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0200, 32'h40,       1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0204};
    vecs[7]  = '{4'd5,  32'd7,        32'd7,        32'h0000_0300, 32'h100,       1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0400};
    vecs[8]  = '{4'd2,  32'd3,        32'd3,        32'hFFFF_FFFC, 32'h8,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[9]  = '{4'hA,  32'd0,        32'd0,        32'h0000_0500, 32'h10,        1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0504};
    vecs[10] = '{4'd6,  32'd0,        32'd0,        32'h0000_0504, 32'h10,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0508};
    vecs[11] = '{4'd3,  32'hFFFF_FFFF, 32'd0,       32'h0000_0600, 32'h8,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0608};
    vecs[12] = '{4'd0,  32'h1234_5678, 32'h1234_5679, 32'h0000_0700, 32'h8,       1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0704};

    sat_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    lookup_pc     = 32'h200;
    pc            = '0;
    op_a          = '0;
    op_b          = '0;
    imm           = '0;
    opcode        = '0;
    pred_taken_in = 1'b0;
    do_reset();

    check("reset_valid",    {31'd0, valid_out},      32'd0);
    check("reset_ready",    {31'd0, ready_out},      32'd1);
    check("reset_taken",    {31'd0, taken},          32'd0);
    check("reset_mispred",  {31'd0, mispredict},     32'd0);
    check("reset_illegal",  {31'd0, illegal},        32'd0);
    check("reset_redirect", redirect_pc,             32'd0);
    check("reset_pred",     {31'd0, pred_taken_out}, 32'd0);

    // Compare vectors streamed one per cycle; each result is checked while the next op is offered.
    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("vec%0d_valid", i-1),    {31'd0, valid_out},  32'd1);
        check($sformatf("vec%0d_taken", i-1),    {31'd0, taken},      {31'd0, vecs[i-1].exp_taken});
        check($sformatf("vec%0d_mispred", i-1),  {31'd0, mispredict}, {31'd0, vecs[i-1].exp_mis});
        check($sformatf("vec%0d_illegal", i-1),  {31'd0, illegal},    {31'd0, vecs[i-1].exp_ill});
        check($sformatf("vec%0d_redirect", i-1), redirect_pc,         vecs[i-1].exp_rpc);
        check($sformatf("vec%0d_ready", i-1),    {31'd0, ready_out},  32'd1);
      end
      if (i < NV)
        drive_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].imm, vecs[i].pred);
      else
        valid_in = 1'b0;
    end
    @(negedge clk);
    check("stream_drain_valid", {31'd0, valid_out}, 32'd0);

    // Saturation at pc 0x200: four taken then three not-taken; the update-cycle lookup sees the old value.
    do_reset();
    lookup_pc = 32'h200;
    prev_pred = 1'b0;
    check("sat_initial", {31'd0, pred_taken_out}, 32'd0);
    for (int k = 0; k < 7; k++) begin
      drive_op(4'd0, 32'd7, (k < 4) ? 32'd7 : 32'd8, 32'h200, 32'h10, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("sat%0d_taken", k), {31'd0, taken}, (k < 4) ? 32'd1 : 32'd0);
      check($sformatf("sat%0d_pre", k), {31'd0, pred_taken_out}, {31'd0, prev_pred});
      valid_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("sat%0d_post", k), {31'd0, pred_taken_out}, {31'd0, sat_exp[k]});
      prev_pred = sat_exp[k];
    end

    // Backpressure: held taken op at 0x200, second op waits, accepted when ready_i rises.
    do_reset();
    lookup_pc = 32'h200;
    ready_in  = 1'b0;
    drive_op(4'd0, 32'd7, 32'd7, 32'h200, 32'h10, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive_op(4'd1, 32'd1, 32'd2, 32'h208, 32'h40, 1'b1);
    held_rpc = 32'h210;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("stall%0d_valid", s),    {31'd0, valid_out},      32'd1);
      check($sformatf("stall%0d_ready", s),    {31'd0, ready_out},      32'd0);
      check($sformatf("stall%0d_taken", s),    {31'd0, taken},          32'd1);
      check($sformatf("stall%0d_mispred", s),  {31'd0, mispredict},     32'd1);
      check($sformatf("stall%0d_redirect", s), redirect_pc,             held_rpc);
      check($sformatf("stall%0d_pred", s),     {31'd0, pred_taken_out}, 32'd0);
      if (s < 2) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    ready_in = 1'b1;
    #1;
    check("bp_ready_rise", {31'd0, ready_out}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("bp_op2_valid",    {31'd0, valid_out},      32'd1);
    check("bp_op2_redirect", redirect_pc,             32'h248);
    check("bp_op2_mispred",  {31'd0, mispredict},     32'd0);
    check("bp_single_upd",   {31'd0, pred_taken_out}, 32'd1);
    valid_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("bp_drain_valid", {31'd0, valid_out},      32'd0);
    check("bp_after_pred",  {31'd0, pred_taken_out}, 32'd1);
    lookup_pc = 32'h208;
    #1;
    check("bp_op2_trained", {31'd0, pred_taken_out}, 32'd1);

    // Flush a held result while a new op is offered: nothing survives, no counter moves.
    do_reset();
    ready_in = 1'b0;
    drive_op(4'd0, 32'd7, 32'd7, 32'h200, 32'h10, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("flush_held_valid", {31'd0, valid_out}, 32'd1);
    drive_op(4'd0, 32'd3, 32'd3, 32'h204, 32'h10, 1'b0);
    flush    = 1'b1;
    ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b0;
    valid_in = 1'b0;
    check("flush_valid_next", {31'd0, valid_out}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("flush_no_capture", {31'd0, valid_out}, 32'd0);
    lookup_pc = 32'h200;
    #1;
    check("flush_bht_200", {31'd0, pred_taken_out}, 32'd0);
    lookup_pc = 32'h204;
    #1;
    check("flush_bht_204", {31'd0, pred_taken_out}, 32'd0);

    // Illegal opcode must not touch a trained counter (0x200 trained to 2).
    @(negedge clk);
    lookup_pc = 32'h200;
    taken_op(32'h200);
    check("ill_trained", {31'd0, pred_taken_out}, 32'd1);
    drive_op(4'hA, 32'd0, 32'd0, 32'h200, 32'h10, 1'b1);
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    check("ill_flag",    {31'd0, illegal},    32'd1);
    check("ill_taken",   {31'd0, taken},      32'd0);
    check("ill_mispred", {31'd0, mispredict}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("ill_no_upd", {31'd0, pred_taken_out}, 32'd1);

    // Asynchronous reset in the middle of a stall with trained counters.
    taken_op(32'h200);
    taken_op(32'h300);
    taken_op(32'h300);
    ready_in = 1'b0;
    drive_op(4'd0, 32'd1, 32'd1, 32'h200, 32'h40, 1'b0);
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    check("rst_pre_valid", {31'd0, valid_out},      32'd1);
    check("rst_pre_pred",  {31'd0, pred_taken_out}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid",    {31'd0, valid_out},      32'd0);
    check("rst_async_redirect", redirect_pc,             32'd0);
    check("rst_async_taken",    {31'd0, taken},          32'd0);
    check("rst_async_ready",    {31'd0, ready_out},      32'd1);
    check("rst_async_pred",     {31'd0, pred_taken_out}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lookup_pc = 32'h300;
    #1;
    check("rst_release_300", {31'd0, pred_taken_out}, 32'd0);
    lookup_pc = 32'h200;
    #1;
    check("rst_release_200", {31'd0, pred_taken_out}, 32'd0);
    check("rst_release_valid", {31'd0, valid_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
